seven_seg_scanner: RTL
======================

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, meaning clk cycles each digit is lit (legal range 2..2^20).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port value  input  32  eight hex nibbles; nibble k (value[4k+3:4k]) drives digit k.
REQ-005 SHALL have port load  input  1  single-cycle strobe that captures value and dp_en.
REQ-006 SHALL have port dp_en  input  8  bit k high lights the decimal point of digit k.
REQ-007 SHALL have port digit_en  input  8  bit k low blanks digit k; sampled live, not latched.
REQ-008 SHALL have port AN  output  8  active-low anode enables, at most one bit low.
REQ-009 SHALL have port CX  output  8  active-low cathodes {a,b,c,d,e,f,g,dp}, CX[7]=a, CX[0]=dp.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse when digit 7's slot ends.

Function
REQ-011 SHALL hold a refresh counter counting 0..REFRESH_DIV-1, wrapping to 0; the cycle with count REFRESH_DIV-1 is a "tick".
REQ-012 SHALL hold a 3-bit digit index, incremented on each tick, wrapping 7->0.
REQ-013 SHALL define a frame boundary as a tick while the digit index is 7.
REQ-014 SHALL, on load, capture value and dp_en into a pending register; a load with no frame boundary in the same cycle SHALL NOT change the displayed digits.
REQ-015 SHALL, at each frame boundary, copy the pending register into the display register.
REQ-016 SHALL, when load and a frame boundary occur in the same cycle, load value and dp_en directly into both the pending and display registers.
REQ-017 SHALL register AN and CX; both reflect the digit index and display register one cycle after they change.
REQ-018 SHALL drive AN as all ones except bit[index]=0; if digit_en[index]=0, AN SHALL be 8'hFF.
REQ-019 SHALL drive CX[7:1] from the display nibble of the current index as hex: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-020 SHALL drive CX[0]=~dp_display[index]; CX SHALL be 8'hFF while the digit is blanked by digit_en.
REQ-021 SHALL assert frame_done (registered) for exactly one cycle, in the cycle after each frame boundary.
REQ-022 SHALL have no combinational path from any input to AN, CX or frame_done.

Reset
REQ-023 SHALL, while reset is high, force counter=0, index=0, pending and display registers=0, AN=8'hFF, CX=8'hFF, frame_done=0.
REQ-024 SHALL give reset priority over load and tick; a load in a reset cycle is discarded.
REQ-025 SHALL, in the first cycle after reset falls, show digit 0 with value 0: AN=8'hFE, CX=8'h03 (digit_en[0]=1, dp off).
REQ-026 SHALL, when reset is asserted mid-frame, restart scanning at digit 0 with a full REFRESH_DIV slot.

Verification (REFRESH_DIV=4)
REQ-027 Reset release with digit_en=FF -> AN walks FE,FD,FB,...,7F, each held 4 cycles, then back to FE; CX=03 throughout; frame_done pulses once every 32 cycles.
REQ-028 load with value=32'h76543210, dp_en=8'h01, mid-frame -> old digits until the frame boundary; then digit0 CX=02, digit1 CX=9F, digit7 CX=1F.
REQ-029 load coincident with a frame boundary, value=32'hFFFFFFFF -> the next frame shows CX=71 on all digits with no old-value frame.
REQ-030 digit_en=8'hF0 -> AN=FF and CX=FF during digit 0-3 slots; digits 4-7 are lit normally, and slot timing is unchanged.
REQ-031 reset pulse during digit 5's slot with a pending load -> AN=FF, CX=FF in the cycle after the reset edge, then AN=FE, CX=03; the pending value is lost.
REQ-032 Two loads within one frame (A then B) -> only B is displayed after the boundary.

Source files
------------

// File: rtl/seven_seg_scanner_if.sv
// ============================================================================
// seven_seg_scanner_if : display data in, anode/cathode drive out
// Rev 1.0
// ============================================================================
`default_nettype none

interface seven_seg_scanner_if;
  logic [31:0] value;
  logic        load;
  logic [7:0]  dp_en;
  logic [7:0]  digit_en;
  logic [7:0]  AN;
  logic [7:0]  CX;
  logic        frame_done;

  modport master (
    output value, load, dp_en, digit_en,
    input  AN, CX, frame_done
  );

  modport slave (
    input  value, load, dp_en, digit_en,
    output AN, CX, frame_done
  );
endinterface

`default_nettype wire

// File: rtl/seven_seg_scanner.sv
// ============================================================================
// seven_seg_scanner : 8-digit multiplexed hex display driver, frame-synced load
// Rev 1.0
// ============================================================================
`default_nettype none

module seven_seg_scanner #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  wire logic           clk,
  input  wire logic           reset,
  seven_seg_scanner_if.slave  bus
);

  localparam int unsigned   C_CW   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [C_CW-1:0] C_LAST = C_CW'(REFRESH_DIV - 1);

  logic [C_CW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [31:0]     pend_q, pend_d;
  logic [31:0]     disp_q, disp_d;
  logic [7:0]      pdp_q, pdp_d;
  logic [7:0]      ddp_q, ddp_d;
  logic [7:0]      an_q, an_d;
  logic [7:0]      cx_q, cx_d;
  logic            fd_q;

  logic            w_tick;
  logic            w_frame;
  logic [3:0]      w_nib;
  logic [6:0]      w_seg;

  always_comb begin
    w_tick  = (cnt_q == C_LAST);
    w_frame = w_tick && (idx_q == 3'd7);
    cnt_d   = w_tick ? '0 : cnt_q + C_CW'(1);
    idx_d   = w_tick ? idx_q + 3'd1 : idx_q;

    pend_d  = pend_q;
    pdp_d   = pdp_q;
    if (bus.load) begin
      pend_d = bus.value;
      pdp_d  = bus.dp_en;
    end

    // A load landing on the boundary bypasses pending so no stale frame is shown.
    disp_d = disp_q;
    ddp_d  = ddp_q;
    if (w_frame) begin
      disp_d = bus.load ? bus.value : pend_q;
      ddp_d  = bus.load ? bus.dp_en : pdp_q;
    end
  end

  always_comb begin
    w_nib = disp_q[{idx_q, 2'b00} +: 4];
    w_seg = 7'b1111111;
    case (w_nib)
      4'h0: w_seg = 7'b0000001;
      4'h1: w_seg = 7'b1001111;
      4'h2: w_seg = 7'b0010010;
      4'h3: w_seg = 7'b0000110;
      4'h4: w_seg = 7'b1001100;
      4'h5: w_seg = 7'b0100100;
      4'h6: w_seg = 7'b0100000;
      4'h7: w_seg = 7'b0001111;
      4'h8: w_seg = 7'b0000000;
      4'h9: w_seg = 7'b0000100;
      4'hA: w_seg = 7'b0001000;
      4'hB: w_seg = 7'b1100000;
      4'hC: w_seg = 7'b0110001;
      4'hD: w_seg = 7'b1000010;
      4'hE: w_seg = 7'b0110000;
      4'hF: w_seg = 7'b0111000;
      default: w_seg = 7'b1111111;
    endcase

    an_d = 8'hFF;
    cx_d = 8'hFF;
    if (bus.digit_en[idx_q]) begin
      an_d = ~(8'b1 << idx_q);
      cx_d = {w_seg, ~ddp_q[idx_q]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      idx_q  <= 3'd0;
      pend_q <= 32'd0;
      disp_q <= 32'd0;
      pdp_q  <= 8'd0;
      ddp_q  <= 8'd0;
      an_q   <= 8'hFF;
      cx_q   <= 8'hFF;
      fd_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      pend_q <= pend_d;
      disp_q <= disp_d;
      pdp_q  <= pdp_d;
      ddp_q  <= ddp_d;
      an_q   <= an_d;
      cx_q   <= cx_d;
      fd_q   <= w_frame;
    end
  end

  assign bus.AN         = an_q;
  assign bus.CX         = cx_q;
  assign bus.frame_done = fd_q;

endmodule

`default_nettype wire
